// File: rtl/seg_scan_if.sv
// Bundles the scanned display lines and the recovered digit readback.
// The tap (master) drives the segment/anode lines and err_clr; the decoder (slave) returns the recovered digits.
interface seg_scan_if #(
    parameter int N_DIGITS = 6
);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [0:6]            seg_n;
    logic [N_DIGITS-1:0]   an_n;
    logic                  err_clr;
    logic [4*N_DIGITS-1:0] digits;
    logic [N_DIGITS-1:0]   digit_valid;
    logic                  upd;
    logic [IW-1:0]         upd_idx;
    logic                  err;

    modport master (
        output seg_n, an_n, err_clr,
        input  digits, digit_valid, upd, upd_idx, err
    );

    modport slave (
        input  seg_n, an_n, err_clr,
        output digits, digit_valid, upd, upd_idx, err
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Recovers BCD digits from multiplexed active-low 7-segment scan lines.
// A digit is committed once its pattern and anode are stable for STABLE_CYCLES clocks.
module seg_scan_decoder #(
    parameter int N_DIGITS      = 6,
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    seg_scan_if.slave bus
);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int SW = 7 + N_DIGITS;

    logic [SW-1:0] sample;
    logic [SW-1:0] s_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          an_valid;
    logic [IW-1:0] an_idx;
    logic [3:0]    code;
    logic          commit;
    logic          upd_q;
    logic [IW-1:0] upd_idx_q;
    logic          err_q, err_d;

    assign sample = {bus.seg_n, bus.an_n};

    always_comb begin
        an_valid = ($countones(~bus.an_n) == 1);
        an_idx   = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!bus.an_n[i]) an_idx = IW'(i);
        end
    end

    // Literal bit order matches seg_n[0:6]: leftmost character is segment a.
    always_comb begin
        case (bus.seg_n)
            7'b0000001: code = 4'd0;
            7'b1001111: code = 4'd1;
            7'b0010010: code = 4'd2;
            7'b0000110: code = 4'd3;
            7'b1001100: code = 4'd4;
            7'b0100100: code = 4'd5;
            7'b0100000: code = 4'd6;
            7'b0001101: code = 4'd7;
            7'b0000000: code = 4'd8;
            7'b0000100: code = 4'd9;
            7'b1111111: code = 4'hF;
            default:    code = 4'hE;
        endcase
    end

    // cnt_q encodes IDLE (0), COUNT (1..S-1) and LOCKED (S); saturation prevents re-commit.
    always_comb begin
        cnt_d  = cnt_q;
        commit = 1'b0;
        if (!an_valid) begin
            cnt_d = '0;
        end else if (sample != s_q) begin
            cnt_d = CW'(1);
        end else if (cnt_q != CW'(STABLE_CYCLES)) begin
            cnt_d  = cnt_q + CW'(1);
            commit = (cnt_q == CW'(STABLE_CYCLES - 1));
        end
    end

    always_comb begin
        err_d = err_q;
        if (commit && code == 4'hE) begin
            err_d = 1'b1;
        end else if (bus.err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q       <= '1;
            cnt_q     <= '0;
            upd_q     <= 1'b0;
            upd_idx_q <= '0;
            err_q     <= 1'b0;
        end else begin
            s_q       <= sample;
            cnt_q     <= cnt_d;
            upd_q     <= commit;
            err_q     <= err_d;
            if (commit) upd_idx_q <= an_idx;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            logic [3:0] digit_q;
            logic       valid_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    digit_q <= 4'hF;
                    valid_q <= 1'b0;
                end else if (commit && an_idx == IW'(gi)) begin
                    digit_q <= code;
                    valid_q <= 1'b1;
                end
            end

            assign bus.digits[4*gi +: 4] = digit_q;
            assign bus.digit_valid[gi]   = valid_q;
        end
    endgenerate

    assign bus.upd     = upd_q;
    assign bus.upd_idx = upd_idx_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: table-driven scan vectors with a commit scoreboard,
// plus hand sequences for latency, glitches, invalid anodes, errors and reset.
module tb_seg_scan_decoder;
    localparam int N = 6;

    typedef struct {
        logic [0:6] seg;
        logic [5:0] an;
        logic [3:0] code;
        int         idx;
    } vec_t;

    typedef struct {
        int         idx;
        logic [3:0] code;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int checks = 0;
    int errors = 0;
    int upd_seen = 0;
    exp_t exp_q[$];
    vec_t vecs[10];
    logic [3:0] model [N];

    seg_scan_if #(.N_DIGITS(N)) bus ();

    seg_scan_decoder #(.N_DIGITS(N), .STABLE_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic drive(input logic [0:6] seg, input logic [5:0] an);
        bus.seg_n = seg;
        bus.an_n  = an;
    endtask

    task automatic expect_commit(input int idx, input logic [3:0] code);
        exp_t e;
        e.idx  = idx;
        e.code = code;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every upd pulse must match the oldest expected commit.
    always @(negedge clk) begin
        if (bus.upd === 1'b1) begin
            exp_t e;
            logic [3:0] got;
            upd_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_upd: got idx=%0d digits=%h expected no commit",
                         bus.upd_idx, bus.digits);
            end else begin
                e   = exp_q.pop_front();
                got = bus.digits[4*e.idx +: 4];
                if (int'(bus.upd_idx) != e.idx || got !== e.code) begin
                    errors++;
                    $display("FAIL commit: got idx=%0d code=%h expected idx=%0d code=%h",
                             bus.upd_idx, got, e.idx, e.code);
                end else begin
                    $display("upd  idx=%0d code=%h", e.idx, got);
                end
            end
        end
    end

    initial begin
        int base;

        vecs[0] = '{7'b1001111, 6'b011111, 4'd1, 5};
        vecs[1] = '{7'b0010010, 6'b101111, 4'd2, 4};
        vecs[2] = '{7'b0000110, 6'b110111, 4'd3, 3};
        vecs[3] = '{7'b1001100, 6'b111011, 4'd4, 2};
        vecs[4] = '{7'b0100100, 6'b111101, 4'd5, 1};
        vecs[5] = '{7'b0100000, 6'b111110, 4'd6, 0};
        vecs[6] = '{7'b0000001, 6'b111110, 4'd0, 0};
        vecs[7] = '{7'b0001101, 6'b111101, 4'd7, 1};
        vecs[8] = '{7'b0000000, 6'b111011, 4'd8, 2};
        vecs[9] = '{7'b0000100, 6'b110111, 4'd9, 3};

        bus.err_clr = 1'b0;
        drive(7'b1111111, 6'b111111);

        // Reset asserted mid-cycle takes effect immediately
        #3 rst_n = 1'b0;
        #1;
        chk("rst_digits", 32'(bus.digits), 32'hFFFFFF);
        chk("rst_valid", 32'(bus.digit_valid), 32'h0);
        chk("rst_upd", 32'(bus.upd), 32'h0);
        chk("rst_err", 32'(bus.err), 32'h0);
        tick();
        #2 rst_n = 1'b1;
        tick();

        // Single commit after exactly 4 edges, then no repeat while held
        base = upd_seen;
        drive(7'b0000110, 6'b111011);
        expect_commit(2, 4'd3);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("lat_upd_edge%0d", k), 32'(bus.upd), (k == 4) ? 32'h1 : 32'h0);
        end
        chk("lat_upd_idx", 32'(bus.upd_idx), 32'd2);
        repeat (20) tick();
        chk("hold_single_upd", 32'(upd_seen - base), 32'd1);
        chk("hold_digit2", 32'(bus.digits[11:8]), 32'd3);
        chk("hold_valid", 32'(bus.digit_valid), 32'b000100);

        // Glitch: 3 stable cycles then a change must not commit
        base = upd_seen;
        drive(7'b0010010, 6'b111110);
        repeat (3) tick();
        drive(7'b1001100, 6'b111110);
        expect_commit(0, 4'd4);
        repeat (5) tick();
        chk("glitch_upd_count", 32'(upd_seen - base), 32'd1);
        chk("glitch_digit0", 32'(bus.digits[3:0]), 32'd4);

        // Invalid anode patterns never commit
        base = upd_seen;
        drive(7'b0000110, 6'b111111);
        repeat (10) tick();
        drive(7'b0000110, 6'b111100);
        repeat (10) tick();
        chk("invalid_an_no_upd", 32'(upd_seen - base), 32'd0);

        // Unrecognised pattern -> E and sticky err; err_clr; blank clears to F without err
        drive(7'b1111110, 6'b011111);
        expect_commit(5, 4'hE);
        repeat (5) tick();
        chk("bad_digit5", 32'(bus.digits[23:20]), 32'hE);
        chk("bad_err_set", 32'(bus.err), 32'h1);
        repeat (3) tick();
        chk("err_sticky", 32'(bus.err), 32'h1);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("err_cleared", 32'(bus.err), 32'h0);
        drive(7'b1111111, 6'b011111);
        expect_commit(5, 4'hF);
        repeat (5) tick();
        chk("blank_digit5", 32'(bus.digits[23:20]), 32'hF);
        chk("blank_no_err", 32'(bus.err), 32'h0);

        // Table-driven scan: 12:34:56 then further codes
        for (int i = 0; i < N; i++) model[i] = 4'hF;
        base = upd_seen;
        for (int v = 0; v < 10; v++) begin
            drive(vecs[v].seg, vecs[v].an);
            expect_commit(vecs[v].idx, vecs[v].code);
            model[vecs[v].idx] = vecs[v].code;
            repeat (5) tick();
            if (v == 5) begin
                chk("scan_hhmmss", 32'(bus.digits), 32'h123456);
                chk("scan_valid_all", 32'(bus.digit_valid), 32'b111111);
            end
        end
        chk("scan_upd_count", 32'(upd_seen - base), 32'd10);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("scan_model_digit%0d", i), 32'(bus.digits[4*i +: 4]), 32'(model[i]));
        end

        // Reset after 2 cycles of a slot: no commit, everything back to reset values
        base = upd_seen;
        drive(7'b0100100, 6'b111011);
        repeat (2) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_digits", 32'(bus.digits), 32'hFFFFFF);
        chk("midrst_valid", 32'(bus.digit_valid), 32'h0);
        repeat (4) tick();
        drive(7'b1111111, 6'b111111);
        tick();
        #2 rst_n = 1'b1;
        repeat (6) tick();
        chk("midrst_no_upd", 32'(upd_seen - base), 32'd0);
        chk("midrst_err", 32'(bus.err), 32'h0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
